// File: rtl/step_sched_pkg.sv
// Shared types for the step scheduler: FSM state encoding, queued move entry,
// and the helper that clamps a requested interval to the shortest legal period.
package step_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIR_SETUP,
    ST_STEP_HIGH,
    ST_STEP_WAIT,
    ST_DWELL
  } state_e;

  typedef struct packed {
    logic [15:0] interval;
    logic [15:0] count;
    logic        dir;
  } move_t;

  // A step period can never be shorter than the pulse plus one low cycle.
  function automatic logic [15:0] eff_interval(input logic [15:0] iv, input int pulse);
    logic [15:0] floor_v;
    floor_v = 16'(pulse + 1);
    return (iv < floor_v) ? floor_v : iv;
  endfunction

endpackage

// File: rtl/step_fifo.sv
// Move queue: DEPTH-entry synchronous FIFO with registered occupancy.
// Head data is read from storage, so a pushed entry is poppable one cycle later.
module step_fifo
  import step_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  move_t                    din,
  output move_t                    dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  move_t           mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     level_q;

  assign level = level_q;
  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/step_sched.sv
// Step/direction motor pulse scheduler fed from a small move queue.
// Entries chain back-to-back; a direction change inserts a setup gap before the next rise.
//
// state        | meaning
// IDLE         | nothing active, waiting for enable and a queued entry
// DIR_SETUP    | dir_o just changed, holding step_o low for the setup time
// STEP_HIGH    | step_o high for the pulse width
// STEP_WAIT    | step_o low until the step interval expires
// DWELL        | zero-count entry, idle for one interval
module step_sched
  import step_sched_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DIR_SETUP = 4,
  parameter int PULSE     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    abort,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [15:0]             wr_interval,
  input  logic [15:0]             wr_count,
  input  logic                    wr_dir,
  input  logic                    pos_clr,
  output logic                    step_o,
  output logic                    dir_o,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level,
  output logic [31:0]             position
);

  localparam logic [15:0] PULSE_M1 = 16'(PULSE - 1);
  localparam logic [15:0] SETUP_M1 = 16'(DIR_SETUP - 1);

  state_e       state_q;
  logic [15:0]  tmr_q, rem_q, ivl_q, pls_q;
  logic         push, pop, empty, full;
  logic         tmr_done, entry_end, chain_step, rise;
  logic [15:0]  head_ivl;
  logic [31:0]  step_delta;
  move_t        wr_entry, head;

  assign wr_ready = !full && !abort;
  assign push     = wr_valid && wr_ready;
  assign wr_entry = '{interval: wr_interval, count: wr_count, dir: wr_dir};
  assign busy     = (state_q != ST_IDLE);

  step_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  assign tmr_done   = (tmr_q == 16'd0);
  assign entry_end  = tmr_done && (rem_q == 16'd0) &&
                      (state_q == ST_STEP_WAIT || state_q == ST_DWELL);
  assign pop        = !abort && enable && !empty && (state_q == ST_IDLE || entry_end);
  assign head_ivl   = eff_interval(head.interval, PULSE);
  // Chaining into a same-direction entry steps on the old interval boundary with no setup gap.
  assign chain_step = pop && (state_q != ST_IDLE) && (head.count != 16'd0) && (head.dir == dir_o);
  assign rise       = !abort && (chain_step ||
                      (tmr_done && ((state_q == ST_DIR_SETUP) ||
                                    (state_q == ST_STEP_WAIT && rem_q != 16'd0))));
  assign step_delta = dir_o ? 32'd1 : '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      step_o   <= 1'b0;
      dir_o    <= 1'b0;
      tmr_q    <= '0;
      rem_q    <= '0;
      ivl_q    <= '0;
      pls_q    <= '0;
      position <= '0;
    end else begin
      if (rise)         position <= (pos_clr ? 32'd0 : position) + step_delta;
      else if (pos_clr) position <= '0;

      if (abort) begin
        state_q <= ST_IDLE;
        step_o  <= 1'b0;
      end else if (pop) begin
        ivl_q <= head_ivl;
        tmr_q <= head_ivl - 16'd1;
        if (head.count == 16'd0) begin
          state_q <= ST_DWELL;
          rem_q   <= '0;
        end else if (chain_step) begin
          state_q <= ST_STEP_HIGH;
          step_o  <= 1'b1;
          pls_q   <= PULSE_M1;
          rem_q   <= head.count - 16'd1;
        end else begin
          state_q <= ST_DIR_SETUP;
          dir_o   <= head.dir;
          rem_q   <= head.count;
          tmr_q   <= SETUP_M1;
        end
      end else begin
        case (state_q)
          ST_DIR_SETUP, ST_STEP_WAIT: begin
            if (rise) begin
              state_q <= ST_STEP_HIGH;
              step_o  <= 1'b1;
              pls_q   <= PULSE_M1;
              rem_q   <= rem_q - 16'd1;
              tmr_q   <= ivl_q - 16'd1;
            end else if (tmr_done) begin
              state_q <= ST_IDLE;
            end else begin
              tmr_q <= tmr_q - 16'd1;
            end
          end
          ST_STEP_HIGH: begin
            if (!tmr_done) tmr_q <= tmr_q - 16'd1;
            if (pls_q == 16'd0) begin
              step_o  <= 1'b0;
              state_q <= ST_STEP_WAIT;
            end else begin
              pls_q <= pls_q - 16'd1;
            end
          end
          ST_DWELL: begin
            if (tmr_done) state_q <= ST_IDLE;
            else          tmr_q   <= tmr_q - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_sched.sv
// Directed bench for step_sched: pulse timing, chaining, queue limits, abort and reset.
module tb_step_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        abort = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_interval = '0;
  logic [15:0] wr_count = '0;
  logic        wr_dir = 1'b0;
  logic        pos_clr = 1'b0;
  logic        step_o, dir_o, busy;
  logic [2:0]  level;
  logic [31:0] position;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0;
  int rise_t[$];
  int width_q[$];
  int dir_t = 0;
  int hi_cnt = 0;
  logic prev_step = 1'b0;
  logic prev_dir = 1'b0;

  step_sched #(.DEPTH(4), .DIR_SETUP(4), .PULSE(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .abort       (abort),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_interval (wr_interval),
    .wr_count    (wr_count),
    .wr_dir      (wr_dir),
    .pos_clr     (pos_clr),
    .step_o      (step_o),
    .dir_o       (dir_o),
    .busy        (busy),
    .level       (level),
    .position    (position)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (step_o === 1'b1 && prev_step !== 1'b1) begin
      rise_t.push_back(cyc);
      hi_cnt = 1;
    end else if (step_o === 1'b1) begin
      hi_cnt++;
    end else if (prev_step === 1'b1) begin
      width_q.push_back(hi_cnt);
    end
    if (dir_o !== prev_dir) dir_t = cyc;
    prev_step = step_o;
    prev_dir  = dir_o;
  end

  function automatic int rise_at(input int i);
    return (i < rise_t.size()) ? rise_t[i] : -100000;
  endfunction

  function automatic int width_at(input int i);
    return (i < width_q.size()) ? width_q[i] : -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rise_t.delete();
    width_q.delete();
  endtask

  task automatic push(input logic [15:0] iv, input logic [15:0] cnt, input logic d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_interval = iv;
    wr_count = cnt;
    wr_dir = d;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy !== 1'b0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check1("idle_reached", busy, 1'b0);
  endtask

  task automatic wait_step(input int max_cyc);
    int n;
    n = 0;
    while (step_o !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check1("step_seen", step_o, 1'b1);
  endtask

  task automatic run_basic(input string t);
    clear_mon();
    push(16'd10, 16'd3, 1'b1);
    wait_idle(100);
    check({t, "_rises"}, rise_t.size(), 3);
    check({t, "_setup"}, rise_at(0) - dir_t, 4);
    check({t, "_gap1"}, rise_at(1) - rise_at(0), 10);
    check({t, "_gap2"}, rise_at(2) - rise_at(1), 10);
    for (int i = 0; i < 3; i++) check($sformatf("%s_width%0d", t, i), width_at(i), 2);
    check({t, "_pos"}, position, 3);
    check1({t, "_dir"}, dir_o, 1'b1);
  endtask

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    check1("rst_step", step_o, 1'b0);
    check1("rst_dir", dir_o, 1'b0);
    check("rst_pos", position, 0);
    check1("rst_busy", busy, 1'b0);
    check("rst_level", 32'(level), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check1("rel_ready", wr_ready, 1'b1);
    check("rel_level", 32'(level), 0);

    // single move
    enable = 1'b1;
    run_basic("basic");

    // position clear, then same-dir chain and a direction change
    @(negedge clk);
    pos_clr = 1'b1;
    @(negedge clk);
    pos_clr = 1'b0;
    check("clr_pos", position, 0);
    clear_mon();
    push(16'd10, 16'd2, 1'b1);
    push(16'd10, 16'd2, 1'b1);
    push(16'd10, 16'd2, 1'b0);
    wait_idle(200);
    check("chain_rises", rise_t.size(), 6);
    check("chain_gap1", rise_at(1) - rise_at(0), 10);
    check("chain_gap2", rise_at(2) - rise_at(1), 10);
    check("chain_gap3", rise_at(3) - rise_at(2), 10);
    check("chain_gap4", rise_at(4) - rise_at(3), 14);
    check("chain_gap5", rise_at(5) - rise_at(4), 10);
    check("chain_dirchg", dir_t - rise_at(3), 10);
    check("chain_pos", position, 2);
    check1("chain_dir", dir_o, 1'b0);

    // fill with enable low, fifth push stalls
    @(negedge clk);
    enable = 1'b0;
    clear_mon();
    push(16'd1, 16'd4, 1'b1);
    push(16'd20, 16'd0, 1'b0);
    push(16'd5, 16'd1, 1'b1);
    push(16'd5, 16'd1, 1'b1);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_interval = 16'd7;
    wr_count = 16'd7;
    wr_dir = 1'b0;
    check1("full_ready", wr_ready, 1'b0);
    check("full_level", 32'(level), 4);
    repeat (3) @(negedge clk);
    check("full_level_hold", 32'(level), 4);
    check("full_no_step", rise_t.size(), 0);
    check1("full_not_busy", busy, 1'b0);
    wr_valid = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check("run_level", 32'(level), 3);
    check1("run_busy", busy, 1'b1);
    check1("run_dir", dir_o, 1'b1);
    wait_idle(200);
    check("short_rises", rise_t.size(), 6);
    check("short_setup", rise_at(0) - dir_t, 4);
    check("short_gap1", rise_at(1) - rise_at(0), 3);
    check("short_gap2", rise_at(2) - rise_at(1), 3);
    check("short_gap3", rise_at(3) - rise_at(2), 3);
    check("dwell_gap", rise_at(4) - rise_at(3), 23);
    check("after_dwell_gap", rise_at(5) - rise_at(4), 5);
    check("short_width", width_at(1), 2);
    check("short_pos", position, 8);

    // abort during a pulse with three entries waiting
    @(negedge clk);
    enable = 1'b0;
    clear_mon();
    repeat (4) push(16'd10, 16'd5, 1'b1);
    @(negedge clk);
    check("ab_level4", 32'(level), 4);
    enable = 1'b1;
    wait_step(20);
    check("ab_level3", 32'(level), 3);
    check("ab_pos_pre", position, 9);
    abort = 1'b1;
    #1;
    check1("ab_ready_low", wr_ready, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    check1("ab_step", step_o, 1'b0);
    check("ab_level", 32'(level), 0);
    check1("ab_busy", busy, 1'b0);
    check("ab_pos", position, 9);
    check1("ab_dir", dir_o, 1'b1);
    check1("ab_ready", wr_ready, 1'b1);
    repeat (15) @(negedge clk);
    check("ab_quiet", rise_t.size(), 1);
    check1("ab_still_idle", busy, 1'b0);

    // asynchronous reset mid-pulse, then a clean restart
    clear_mon();
    push(16'd10, 16'd3, 1'b1);
    wait_step(20);
    rst_n = 1'b0;
    #1;
    check1("arst_step", step_o, 1'b0);
    check1("arst_dir", dir_o, 1'b0);
    check("arst_pos", position, 0);
    check1("arst_busy", busy, 1'b0);
    check("arst_level", 32'(level), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_basic("restart");

    // clear coincident with a rise leaves exactly one step counted
    pos_clr = 1'b1;
    push(16'd10, 16'd2, 1'b0);
    wait_step(30);
    check("clr_rise", position, 32'hFFFF_FFFF);
    @(negedge clk);
    check("clr_hold", position, 0);
    pos_clr = 1'b0;
    wait_idle(100);
    check("clr_after", position, 32'hFFFF_FFFF);
    check1("clr_dir", dir_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/step_sched.md
STEP_SCHED -- requirements
Module: step_sched

Interface
REQ-001 Parameter: DEPTH, default 4; move queue entries (power of two).
REQ-002 Parameter: DIR_SETUP, default 4; cycles from dir_o change to step_o rise.
REQ-003 Parameter: PULSE, default 2; step_o high width in cycles.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  in  1  sole clock, rising edge.
REQ-006 Port: rst_n  in  1  asynchronous active-low reset.
REQ-007 Port: enable  in  1  permits starting new queue entries.
REQ-008 Port: abort  in  1  synchronous flush and stop.
REQ-009 Port: wr_valid / wr_ready  in/out  1/1  queue push handshake.
REQ-010 Port: wr_interval  in  16  cycles between step rising edges.
REQ-011 Port: wr_count  in  16  number of steps; 0 = dwell.
REQ-012 Port: wr_dir  in  1  direction for the entry.
REQ-013 Port: pos_clr  in  1  synchronous clear of position.
REQ-014 Port: step_o, dir_o  out  1/1  registered motor outputs.
REQ-015 Port: busy  out  1  state != IDLE.
REQ-016 Port: level  out  $clog2(DEPTH)+1  queue occupancy.
REQ-017 Port: position  out  32  signed step position.

Function
REQ-018 Push accepted on wr_valid && wr_ready; wr_ready = !full && !abort.
REQ-019 Pop only from non-empty queue; no fall-through (pushed entry is poppable the following cycle at earliest).
REQ-020 Simultaneous push and pop when not full: both occur, level unchanged.
REQ-021 States: IDLE, DIR_SETUP, STEP_HIGH, STEP_WAIT, DWELL.
REQ-022 IDLE: enable && !empty -> pop head into active regs; count>0 -> DIR_SETUP (dir_o <= entry dir); count==0 -> DWELL (dir_o unchanged).
REQ-023 DIR_SETUP: step_o low; step_o rises exactly DIR_SETUP cycles after the edge dir_o changed.
REQ-024 STEP_HIGH: step_o high exactly PULSE cycles; remaining count decrements on rise.
REQ-025 Interval measured rising-edge to rising-edge; effective interval = max(wr_interval, PULSE+1).
REQ-026 STEP_WAIT: step_o low until interval expires; then remaining>0 -> STEP_HIGH.
REQ-027 Entry end (remaining==0 and interval expired): enable && !empty -> pop next without idle cycle; same dir -> STEP_HIGH immediately; different dir -> DIR_SETUP; else IDLE.
REQ-028 DWELL: no step for effective interval cycles, then entry-end rule.
REQ-029 enable low never truncates the active entry; only blocks next pop.
REQ-030 position +1 per step rise when dir_o=1, -1 when 0; wraps modulo 2^32.
REQ-031 pos_clr zeroes position; coincident with step rise -> position = +/-1.
REQ-032 abort: next edge empties queue, step_o=0, state IDLE; dir_o and position held; abort beats push and pop.

Reset
REQ-033 rst_n low: state IDLE, queue empty, step_o=0, dir_o=0, position=0, counters 0; level=0, busy=0, wr_ready=1 after release.
REQ-034 Reset mid-pulse drops step_o immediately (asynchronous).

Structure
REQ-035 Shared package holds the state enum and move-entry struct (interval, count, dir).
REQ-036 One sub-module natural: step_fifo (DEPTH-entry synchronous FIFO with level).
REQ-037 All outputs registered; no combinational path input-to-step_o/dir_o.

Verification
REQ-038 Push {interval=10,count=3,dir=1}, enable=1 -> dir_o=1, 3 pulses 2 cycles wide, rises 10 apart, first rise 4 cycles after dir_o; position=3; busy low after.
REQ-039 Queue {10,2,1},{10,2,1} -> 4 rises uniformly 10 apart, no DIR_SETUP gap; then {10,2,0} -> 4-cycle setup gap, position 2 after all.
REQ-040 Push 5 entries with enable=0, DEPTH=4 -> 5th stalls wr_ready=0, level=4; no steps until enable.
REQ-041 interval=1,count=4 -> rises 3 cycles apart; {20,0,x} dwell -> 20 cycles no step, dir_o unchanged.
REQ-042 abort during STEP_HIGH with level=3 -> next cycle step_o=0, level=0, busy=0, position retained.
REQ-043 rst_n low mid-move -> all outputs at reset values immediately; restart after release behaves as REQ-038.
